// File: rtl/pulse_sync_arbiter.sv
// pulse_sync_arbiter: round-robin scheduler feeding per-requester event counts into one shared pulse_sync, spaced GAP cycles apart.
module pulse_sync_arbiter #(
  parameter int N_REQ = 4,
  parameter int GAP   = 10,
  parameter int CNT_W = 4
) (
  input  logic                     clk_fast,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_pulse,
  input  logic                     en,
  input  logic                     clr_ovf,
  output logic                     din_en,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic [N_REQ-1:0]         overflow
);
  localparam int ID_W = $clog2(N_REQ);
  localparam int GW   = $clog2(GAP);
  typedef enum logic {IDLE, HOLDOFF} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] pend_q [N_REQ];
  logic [CNT_W-1:0] pend_d [N_REQ];
  logic [ID_W-1:0] last_q, last_d, grant_q, grant_d, win;
  logic [GW-1:0] gap_q, gap_d;
  logic din_en_q, din_en_d, busy_q, busy_d, found, issue, any_d;
  logic [N_REQ-1:0] ovf_q, ovf_d, lost;
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && pend_q[(int'(last_q) + k) % N_REQ] != '0) begin
        found = 1'b1;
        win = ID_W'((int'(last_q) + k) % N_REQ);
      end
    end
    issue = state_q == IDLE && en && found;
    any_d = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      // a saturated counter with no same-edge issue drops the event
      lost[i] = req_pulse[i] && !(issue && win == ID_W'(i)) && &pend_q[i];
      pend_d[i] = lost[i] ? pend_q[i]
                          : pend_q[i] + CNT_W'(req_pulse[i]) - CNT_W'(issue && win == ID_W'(i));
      any_d = any_d || pend_d[i] != '0;
    end
    ovf_d = (ovf_q & ~{N_REQ{clr_ovf}}) | lost;
    din_en_d = issue;
    grant_d = issue ? win : grant_q;
    last_d = issue ? win : last_q;
    gap_d = issue ? GW'(GAP - 1) : (state_q == HOLDOFF ? gap_q - GW'(1) : gap_q);
    state_d = issue ? HOLDOFF : (state_q == HOLDOFF && gap_q == GW'(1) ? IDLE : state_q);
    busy_d = state_d == HOLDOFF || any_d;
  end
  always_ff @(posedge clk_fast) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < N_REQ; i++) pend_q[i] <= '0;
      last_q <= ID_W'(N_REQ - 1);
      grant_q <= '0;
      gap_q <= '0;
      din_en_q <= 1'b0;
      busy_q <= 1'b0;
      ovf_q <= '0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < N_REQ; i++) pend_q[i] <= pend_d[i];
      last_q <= last_d;
      grant_q <= grant_d;
      gap_q <= gap_d;
      din_en_q <= din_en_d;
      busy_q <= busy_d;
      ovf_q <= ovf_d;
    end
  end
  assign din_en = din_en_q;
  assign grant_id = grant_q;
  assign busy = busy_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_pulse_sync_arbiter.sv
// tb_pulse_sync_arbiter: directed stimulus queues expected pulses and status; a negedge monitor scores the DUT against them.
module tb_pulse_sync_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_pulse = '0;
  logic en = 1'b1;
  logic clr_ovf = 1'b0;
  logic din_en, busy;
  logic [1:0] grant_id;
  logic [3:0] overflow;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {int id; int cyc;} pe_t;
  typedef struct {int cyc; logic busy; logic [3:0] ovf; bit rchk;} se_t;
  pe_t pq[$];
  se_t sq[$];
  pulse_sync_arbiter #(.N_REQ(4), .GAP(10), .CNT_W(4)) dut (
    .clk_fast(clk), .rst(rst), .req_pulse(req_pulse), .en(en), .clr_ovf(clr_ovf),
    .din_en(din_en), .grant_id(grant_id), .busy(busy), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    pe_t e;
    se_t s;
    if (din_en) begin
      n_cmp++;
      if (pq.size() == 0) begin
        n_bad++;
        $display("FAIL pulse: din_en with grant_id=%0d at cycle %0d, required no pulse", grant_id, cyc);
      end else begin
        e = pq.pop_front();
        if (grant_id !== 2'(e.id) || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL pulse: grant_id=%0d at cycle %0d, required grant_id=%0d at cycle %0d", grant_id, cyc, e.id, e.cyc);
        end
      end
    end else if (pq.size() != 0 && pq[0].cyc < cyc) begin
      e = pq.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL pulse: no din_en by cycle %0d, required grant_id=%0d at cycle %0d", cyc, e.id, e.cyc);
    end
    if (sq.size() != 0 && sq[0].cyc == cyc) begin
      s = sq.pop_front();
      n_cmp++;
      if (busy !== s.busy || overflow !== s.ovf || (s.rchk && (din_en !== 1'b0 || grant_id !== 2'd0))) begin
        n_bad++;
        $display("FAIL status@%0d: busy=%b overflow=%b din_en=%b grant_id=%0d, required busy=%b overflow=%b%s",
                 cyc, busy, overflow, din_en, grant_id, s.busy, s.ovf, s.rchk ? " din_en=0 grant_id=0" : "");
      end
    end
  end
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic xp(int id, int c);
    pq.push_back('{id: id, cyc: c});
  endtask
  task automatic xs(int c, logic b, logic [3:0] o, bit r);
    sq.push_back('{cyc: c, busy: b, ovf: o, rchk: r});
  endtask
  initial begin
    int c;
    tick(1);
    xs(cyc + 1, 1'b0, 4'b0000, 1'b1);
    tick(2);
    rst = 1'b0;
    tick(2);
    // all four at once: served 0,1,2,3 GAP apart
    c = cyc;
    for (int k = 0; k < 4; k++) xp(k, c + 2 + 10 * k);
    xs(c + 3, 1'b1, 4'b0000, 1'b0);
    req_pulse = 4'b1111;
    tick(1);
    req_pulse = '0;
    tick(45);
    c = cyc;
    xp(0, c + 2);
    xp(3, c + 12);
    req_pulse = 4'b1001;
    tick(1);
    req_pulse = '0;
    tick(25);
    // single request and busy window
    c = cyc;
    xp(2, c + 2);
    xs(c + 1, 1'b1, 4'b0000, 1'b0);
    xs(c + 10, 1'b1, 4'b0000, 1'b0);
    xs(c + 11, 1'b0, 4'b0000, 1'b0);
    req_pulse = 4'b0100;
    tick(1);
    req_pulse = '0;
    tick(20);
    // enable dropped mid hold-off with one event still pending
    c = cyc;
    xp(1, c + 2);
    xs(c + 15, 1'b1, 4'b0000, 1'b0);
    req_pulse = 4'b0010;
    tick(2);
    req_pulse = '0;
    tick(2);
    en = 1'b0;
    tick(16);
    en = 1'b1;
    xp(1, c + 21);
    tick(30);
    // requester 0 pulses every cycle for 12 cycles, including issue edges
    c = cyc;
    for (int k = 0; k < 12; k++) xp(0, c + 2 + 10 * k);
    xs(c + 60, 1'b1, 4'b0000, 1'b0);
    req_pulse = 4'b0001;
    tick(12);
    req_pulse = '0;
    tick(125);
    // saturation: 17 events into a 15-deep counter while disabled
    en = 1'b0;
    c = cyc;
    xs(c + 17, 1'b1, 4'b0010, 1'b0);
    req_pulse = 4'b0010;
    tick(17);
    req_pulse = '0;
    tick(3);
    en = 1'b1;
    for (int k = 0; k < 15; k++) xp(1, c + 21 + 10 * k);
    xs(c + 24, 1'b1, 4'b0010, 1'b0);
    xs(c + 26, 1'b1, 4'b0000, 1'b0);
    tick(5);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    tick(150);
    // reset mid hold-off with three events pending
    c = cyc;
    xp(2, c + 2);
    xs(c + 6, 1'b0, 4'b0000, 1'b1);
    req_pulse = 4'b1111;
    tick(1);
    req_pulse = '0;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(30);
    c = cyc;
    xp(1, c + 2);
    xp(2, c + 12);
    req_pulse = 4'b0110;
    tick(1);
    req_pulse = '0;
    tick(30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
